shift_add_mult: RTL

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/mult_pkg.sv | 34 +++
 rtl/shift_add_ctrl.sv | 93 +++++++++
 rtl/shift_add_mult.sv | 119 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
//------------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the shift-and-add multiplier: the one-hot
//   controller state type and a helper that sizes the iteration counter.
//
//   Contents:
//     state_t      - one-hot encoding of IDLE, TEST, ADD, SHIFT, DONE
//     count_width  - bits needed to hold an iteration count of WIDTH-1
//
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  // One bit per state, so each controller output decodes from a single
  // state bit.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_TEST  = 5'b00010,
    ST_ADD   = 5'b00100,
    ST_SHIFT = 5'b01000,
    ST_DONE  = 5'b10000
  } state_t;

  // Counter width for a countdown from width-1 to 0. Clamped to at least
  // one bit so the smallest operand widths still get a real register.
  function automatic int count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage : mult_pkg

`default_nettype wire

// File: rtl/shift_add_ctrl.sv
//------------------------------------------------------------------------------
// shift_add_ctrl
//   One-hot Moore controller for the shift-and-add multiplier. It sequences
//   TEST -> (ADD) -> SHIFT once per multiplier bit, then DONE, and honours an
//   abort request from any of the iterating states.
//
//   Ports:
//     Clock        in   rising-edge clock
//     ResetN       in   asynchronous active-low reset
//     i_start      in   start request, acted on only in IDLE
//     i_abort      in   cancel request, acted on in TEST/ADD/SHIFT only
//     i_q0         in   current multiplier LSB (selects ADD or SHIFT)
//     i_count_zero in   iteration counter has reached zero
//     o_load       out  controller is in IDLE (datapath loads on Start)
//     o_add        out  controller is in ADD
//     o_shift      out  controller is in SHIFT
//     o_fin        out  controller is in DONE
//     o_busy       out  controller is in any state other than IDLE
//
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_add_ctrl
  import mult_pkg::*;
(
  input  logic Clock,
  input  logic ResetN,
  input  logic i_start,
  input  logic i_abort,
  input  logic i_q0,
  input  logic i_count_zero,
  output logic o_load,
  output logic o_add,
  output logic o_shift,
  output logic o_fin,
  output logic o_busy
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      // Start beats Abort here simply because Abort is not looked at in IDLE.
      ST_IDLE: begin
        if (i_start) w_next = ST_TEST;
      end
      ST_TEST: begin
        if (i_abort)   w_next = ST_IDLE;
        else if (i_q0) w_next = ST_ADD;
        else           w_next = ST_SHIFT;
      end
      ST_ADD: begin
        if (i_abort) w_next = ST_IDLE;
        else         w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (i_abort)           w_next = ST_IDLE;
        else if (i_count_zero) w_next = ST_DONE;
        else                   w_next = ST_TEST;
      end
      // DONE always completes; a pending abort is ignored.
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      // Any corrupted (non one-hot) pattern recovers to IDLE.
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_load  = (r_state == ST_IDLE);
    o_add   = (r_state == ST_ADD);
    o_shift = (r_state == ST_SHIFT);
    o_fin   = (r_state == ST_DONE);
    o_busy  = (r_state != ST_IDLE);
  end

endmodule : shift_add_ctrl

`default_nettype wire

// File: rtl/shift_add_mult.sv
//------------------------------------------------------------------------------
// shift_add_mult
//   Sequential unsigned multiplier using the classic shift-and-add scheme on
//   a {C, A, Q} register chain. One multiplier bit is consumed per iteration;
//   iterations with a set LSB spend an extra cycle in ADD.
//
//   Parameters:
//     WIDTH         operand width in bits (2..32)
//
//   Ports:
//     Clock         in   rising-edge clock
//     ResetN        in   asynchronous active-low reset
//     Start         in   begin a multiply (only accepted while idle)
//     Abort         in   cancel an operation in progress
//     Multiplicand  in   unsigned operand M, captured on accepted Start
//     Multiplier    in   unsigned operand Q, captured on accepted Start
//     Busy          out  operation in progress
//     Done          out  one-cycle pulse coincident with a Product update
//     Product       out  last completed product, held between updates
//
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int c_CW = count_width(WIDTH);

  logic [WIDTH-1:0]   r_a;
  logic               r_c;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_m;
  logic [c_CW-1:0]    r_count;
  logic [2*WIDTH-1:0] r_product;
  logic               r_done;

  logic               w_load;
  logic               w_add;
  logic               w_shift;
  logic               w_fin;
  logic               w_busy;
  logic               w_count_zero;
  logic [WIDTH:0]     w_sum;

  // Full WIDTH+1-bit sum; the top bit lands in C so no carry is lost.
  assign w_sum        = {1'b0, r_a} + {1'b0, r_m};
  assign w_count_zero = (r_count == '0);

  shift_add_ctrl u_ctrl (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .i_start      (Start),
    .i_abort      (Abort),
    .i_q0         (r_q[0]),
    .i_count_zero (w_count_zero),
    .o_load       (w_load),
    .o_add        (w_add),
    .o_shift      (w_shift),
    .o_fin        (w_fin),
    .o_busy       (w_busy)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_a       <= '0;
      r_c       <= 1'b0;
      r_q       <= '0;
      r_m       <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      // Done is registered together with Product so the pulse marks the
      // cycle in which the new product is first visible.
      r_done <= w_fin;

      if (w_load && Start) begin
        r_a     <= '0;
        r_c     <= 1'b0;
        r_q     <= Multiplier;
        r_m     <= Multiplicand;
        r_count <= c_CW'(WIDTH - 1);
      end else if (w_add) begin
        {r_c, r_a} <= w_sum;
      end else if (w_shift) begin
        // Logical right shift of {C,A,Q}; C refills with zero.
        {r_c, r_a, r_q} <= {1'b0, r_c, r_a, r_q[WIDTH-1:1]};
        if (!w_count_zero) begin
          r_count <= r_count - 1'b1;
        end
      end

      if (w_fin) begin
        r_product <= {r_a, r_q};
      end
    end
  end

  assign Busy    = w_busy;
  assign Done    = r_done;
  assign Product = r_product;

endmodule : shift_add_mult

`default_nettype wire
